// File: rtl/gpio_responder.sv
// GPIO block on a valid/ready CPU request/response port: output/direction registers,
// two-flop input synchronizer and per-pin edge-triggered pending interrupts.
module gpio_responder #(
    parameter int NPINS = 16,
    parameter int SPLIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [7:0]       req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             gpio0_irq,
    output logic             gpio1_irq
);

    localparam logic [7:0] A_DIN  = 8'h00;
    localparam logic [7:0] A_DOUT = 8'h04;
    localparam logic [7:0] A_DIR  = 8'h08;
    localparam logic [7:0] A_EN   = 8'h0C;
    localparam logic [7:0] A_POL  = 8'h10;
    localparam logic [7:0] A_PEND = 8'h14;
    localparam logic [7:0] A_SET  = 8'h18;

    localparam logic [NPINS-1:0] LO_MASK = NPINS'((64'd1 << SPLIT) - 64'd1);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [NPINS-1:0]  data_out_q, dir_q, en_q, pol_q, pend_q;
    logic [NPINS-1:0]  data_out_d, dir_d, en_d, pol_d, pend_d;
    logic [NPINS-1:0]  s1_q, s2_q, prev_q;

    logic              accept, addr_err, do_wr;
    logic [31:0]       lane_mask;
    logic [NPINS-1:0]  wmask, wval, w1c, set, edge_v;
    logic [31:0]       load_d;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{req_wstrb[i]}};
        end
        wmask    = NPINS'(lane_mask);
        wval     = NPINS'(req_wdata & lane_mask);
        accept   = (state_q == IDLE) && req_valid;
        addr_err = (req_addr[1:0] != 2'b00) || (req_addr > A_SET) ||
                   (req_write && (req_addr == A_DIN));
        do_wr    = accept && req_write && !addr_err;

        data_out_d = data_out_q;
        dir_d      = dir_q;
        en_d       = en_q;
        pol_d      = pol_q;
        w1c        = '0;
        set        = '0;
        if (do_wr) begin
            case (req_addr)
                A_DOUT:  data_out_d = (data_out_q & ~wmask) | wval;
                A_DIR:   dir_d      = (dir_q & ~wmask) | wval;
                A_EN:    en_d       = (en_q & ~wmask) | wval;
                A_POL:   pol_d      = (pol_q & ~wmask) | wval;
                A_PEND:  w1c        = wval;
                A_SET:   set        = wval;
                default: ;
            endcase
        end

        load_d = '0;
        if (!req_write && !addr_err) begin
            case (req_addr)
                A_DIN:   load_d = 32'(s2_q);
                A_DOUT:  load_d = 32'(data_out_q);
                A_DIR:   load_d = 32'(dir_q);
                A_EN:    load_d = 32'(en_q);
                A_POL:   load_d = 32'(pol_q);
                A_PEND:  load_d = 32'(pend_q);
                default: load_d = '0;
            endcase
        end

        // A newly detected edge or an explicit set beats a W1C in the same cycle.
        edge_v = (pol_q & s2_q & ~prev_q) | (~pol_q & ~s2_q & prev_q);
        pend_d = (pend_q & ~w1c) | edge_v | set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= RESP;
                    rdata_q <= load_d;
                    err_q   <= addr_err;
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            dir_q      <= '0;
            en_q       <= '0;
            pol_q      <= '0;
            pend_q     <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            pol_q      <= pol_d;
            pend_q     <= pend_d;
            s1_q       <= gpio_in;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
        end
    end

    // Outputs are forced low while reset is held, even before the first reset edge.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = !reset && (state_q == RESP);
    assign rsp_rdata = reset ? 32'h0 : rdata_q;
    assign rsp_err   = !reset && err_q;
    assign gpio_out  = reset ? '0 : data_out_q;
    assign gpio_oe   = reset ? '0 : dir_q;
    assign gpio0_irq = !reset && (|(pend_q & en_q & LO_MASK));
    assign gpio1_irq = !reset && (|(pend_q & en_q & ~LO_MASK));

endmodule

// File: tb/tb_gpio_responder.sv
// Directed scenarios plus randomized traffic against a register-file reference model.
module tb_gpio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] gpio_in, gpio_out, gpio_oe;
    logic        gpio0_irq, gpio1_irq;

    always #5 clk = ~clk;

    gpio_responder #(.NPINS(16), .SPLIT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .gpio0_irq(gpio0_irq), .gpio1_irq(gpio1_irq)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: register file indexed by word offset, pin history as a queue.
    localparam int R_DIN = 0, R_DOUT = 1, R_DIR = 2, R_EN = 3, R_POL = 4, R_PEND = 5, R_SET = 6;
    logic [15:0] m_reg [0:6];
    logic        m_busy;
    logic [31:0] m_rd;
    logic        m_err;
    logic [15:0] hist[$];

    task automatic model_edge();
        logic [15:0] s2, prv, edg, w1c, set, bm, wd;
        int idx;
        if (reset) begin
            foreach (m_reg[i]) m_reg[i] = '0;
            m_busy = 1'b0;
            m_rd   = '0;
            m_err  = 1'b0;
            hist   = '{16'h0, 16'h0, 16'h0};
            return;
        end
        s2  = hist[1];
        prv = hist[2];
        edg = (m_reg[R_POL] & s2 & ~prv) | (~m_reg[R_POL] & ~s2 & prv);
        w1c = '0;
        set = '0;
        if (!m_busy && req_valid) begin
            m_busy = 1'b1;
            m_rd   = '0;
            m_err  = (req_addr[1:0] != 2'b00) || (req_addr > 8'h18) ||
                     (req_write && req_addr == 8'h00);
            idx = int'(req_addr) / 4;
            bm  = '0;
            for (int i = 0; i < 2; i++) if (req_wstrb[i]) bm[8*i +: 8] = 8'hFF;
            wd = req_wdata[15:0] & bm;
            if (!m_err) begin
                if (req_write) begin
                    case (idx)
                        R_PEND:  w1c = wd;
                        R_SET:   set = wd;
                        default: m_reg[idx] = (m_reg[idx] & ~bm) | wd;
                    endcase
                end else if (idx == R_DIN) begin
                    m_rd = {16'h0, s2};
                end else if (idx != R_SET) begin
                    m_rd = {16'h0, m_reg[idx]};
                end
            end
        end else if (m_busy && rsp_ready) begin
            m_busy = 1'b0;
        end
        m_reg[R_PEND] = (m_reg[R_PEND] & ~w1c) | edg | set;
        hist.push_front(gpio_in);
        void'(hist.pop_back());
    endtask

    task automatic check_outputs();
        chk("req_ready", req_ready, !m_busy);
        chk("rsp_valid", rsp_valid, m_busy);
        if (m_busy || reset) begin
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", rsp_err, m_err);
        end
        chk("gpio_out", gpio_out, m_reg[R_DOUT]);
        chk("gpio_oe", gpio_oe, m_reg[R_DIR]);
        chk("gpio0_irq", gpio0_irq, |(m_reg[R_PEND] & m_reg[R_EN] & 16'h00FF));
        chk("gpio1_irq", gpio1_irq, |(m_reg[R_PEND] & m_reg[R_EN] & 16'hFF00));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic bus(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
        rsp_ready = 1'b1;
        while (!req_ready && n < 20) begin cycle(); n++; end
        if (n == 20) chk("bus_timeout", req_ready, 1);
        cycle();
        req_valid = 1'b0;
        chk("bus_latency", rsp_valid, 1);
        rd = rsp_rdata;
        er = rsp_err;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd0;
        logic        er;
        int          p;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1; gpio_in = '0;
        repeat (3) cycle();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_out", gpio_out, 0);
        chk("rst_irq1", gpio1_irq, 0);
        reset = 1'b0;
        chk("rst_ready", req_ready, 1);

        // write / readback
        bus(1, 8'h04, 32'h0000A5A5, 4'hF, rd, er);
        bus(1, 8'h08, 32'h0000FFFF, 4'hF, rd, er);
        chk("wr_out", gpio_out, 32'hA5A5);
        chk("wr_oe", gpio_oe, 32'hFFFF);
        bus(0, 8'h04, 32'h0, 4'h0, rd, er);
        chk("rb_data", rd, 32'h0000A5A5);
        chk("rb_err", er, 0);

        // rising edge on pin 0
        bus(1, 8'h10, 32'h1, 4'hF, rd, er);
        bus(1, 8'h0C, 32'h1, 4'hF, rd, er);
        gpio_in[0] = 1'b1;
        cycle();
        cycle();
        chk("irq0_early", gpio0_irq, 0);
        cycle();
        chk("irq0_n2", gpio0_irq, 1);
        chk("irq1_quiet", gpio1_irq, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h14; req_wdata = 32'h1; req_wstrb = 4'hF;
        cycle();
        req_valid = 1'b0;
        chk("w1c_irq0", gpio0_irq, 0);
        cycle();
        bus(0, 8'h14, 32'h0, 4'h0, rd, er);
        chk("w1c_pend", rd, 0);

        // W1C of bit 9 colliding with a falling edge on pin 9
        bus(1, 8'h0C, 32'h200, 4'hF, rd, er);
        gpio_in[9] = 1'b1;
        repeat (4) cycle();
        bus(1, 8'h18, 32'h200, 4'hF, rd, er);
        chk("set_irq1", gpio1_irq, 1);
        gpio_in[9] = 1'b0;
        cycle();
        cycle();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h14; req_wdata = 32'h200; req_wstrb = 4'hF;
        cycle();
        req_valid = 1'b0;
        chk("sc_irq1", gpio1_irq, 1);
        cycle();
        bus(0, 8'h14, 32'h0, 4'h0, rd, er);
        chk("sc_pend9", rd[9], 1);

        // access faults
        bus(0, 8'h1C, 32'h0, 4'h0, rd, er);
        chk("err_1c", er, 1);
        chk("err_1c_data", rd, 0);
        bus(0, 8'h05, 32'h0, 4'h0, rd, er);
        chk("err_05", er, 1);
        chk("err_05_data", rd, 0);
        bus(1, 8'h00, 32'hFFFF, 4'hF, rd, er);
        chk("err_st0", er, 1);
        chk("err_nochg", gpio_out, 32'hA5A5);

        // backpressure with req_valid held
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h08;
        cycle();
        rd0 = rsp_rdata;
        chk("bp_data", rd0, 32'hFFFF);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_hold", rsp_rdata, rd0);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_release", rsp_valid, 0);
        cycle();
        chk("bp_second", rsp_valid, 1);
        req_valid = 1'b0;
        cycle();

        // byte strobe, then reset while a response is pending
        bus(1, 8'h04, 32'h0, 4'hF, rd, er);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h04; req_wdata = 32'h12345678; req_wstrb = 4'b0010;
        cycle();
        req_valid = 1'b0;
        chk("strb_out", gpio_out, 32'h5600);
        cycle();
        reset = 1'b1;
        cycle();
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_out", gpio_out, 0);
        chk("mid_rst_oe", gpio_oe, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        chk("mid_rst_irq0", gpio0_irq, 0);
        reset = 1'b0;
        chk("post_rst_ready", req_ready, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(299) == 0);
            req_valid = $urandom_range(1);
            req_write = $urandom_range(1);
            if ($urandom_range(7) == 0) req_addr = 8'($urandom_range(255));
            else                        req_addr = 8'($urandom_range(6) * 4);
            req_wdata = $urandom;
            req_wstrb = 4'($urandom_range(15));
            rsp_ready = ($urandom_range(3) != 0);
            if ($urandom_range(3) == 0) begin
                p = $urandom_range(15);
                gpio_in[p] = ~gpio_in[p];
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
